// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: EX-stage operand/control bundle and HI/LO read-back for the multiply/divide unit
interface mult_div_unit_if;
    logic        start;
    logic [1:0]  md_op;
    logic        mt_hi;
    logic        mt_lo;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output start, md_op, mt_hi, mt_lo, src_a, src_b, input busy, hi, lo);
    modport slave  (input start, md_op, mt_hi, mt_lo, src_a, src_b, output busy, hi, lo);
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle mult/multu/div/divu with HI/LO registers and mthi/mtlo writes
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic             clk,
    input logic             reset,
    mult_div_unit_if.slave  bus
);
    localparam int CW = $clog2((MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [31:0]   a, b;
    logic [1:0]    op;
    logic [63:0]   prod_u, prod_s, prod;
    logic [31:0]   da, db, q, r, qs, rs, nhi, nlo;

    // Signed divide runs on magnitudes so 0x80000000 / -1 wraps back to 0x80000000 with remainder 0
    always_comb begin
        prod_u = {32'b0, a} * {32'b0, b};
        prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        prod   = op[0] ? prod_s : prod_u;
        da     = (op[0] && a[31]) ? -a : a;
        db     = (op[0] && b[31]) ? -b : b;
        q      = (db == 32'd0) ? 32'd0 : da / db;
        r      = (db == 32'd0) ? 32'd0 : da % db;
        qs     = (op[0] && (a[31] ^ b[31])) ? -q : q;
        rs     = (op[0] && a[31]) ? -r : r;
        nhi    = op[1] ? rs : prod[63:32];
        nlo    = op[1] ? qs : prod[31:0];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
            bus.hi   <= '0;
            bus.lo   <= '0;
            cnt      <= '0;
            a        <= '0;
            b        <= '0;
            op       <= '0;
        end else if (state == IDLE) begin
            if (bus.start) begin
                a        <= bus.src_a;
                b        <= bus.src_b;
                op       <= bus.md_op;
                cnt      <= bus.md_op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                state    <= RUN;
                bus.busy <= 1'b1;
            end else begin
                if (bus.mt_hi) bus.hi <= bus.src_a;
                if (bus.mt_lo) bus.lo <= bus.src_a;
            end
        end else if (cnt == CW'(1)) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
            // Divide by zero still spends its cycles but leaves HI/LO untouched
            if (!(op[1] && b == 32'd0)) begin
                bus.hi <= nhi;
                bus.lo <= nlo;
            end
        end else begin
            cnt <= cnt - CW'(1);
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed checks of latency, arithmetic, reset abort and mthi/mtlo priority
module tb_mult_div_unit;
    logic clk = 1'b0;
    logic reset;
    int   n = 0;
    int   fails = 0;
    int   c;

    mult_div_unit_if bus ();

    mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic mt(input logic wh, input logic wl, input logic [31:0] v);
        @(negedge clk);
        bus.mt_hi = wh; bus.mt_lo = wl; bus.src_a = v;
        @(negedge clk);
        bus.mt_hi = 1'b0; bus.mt_lo = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] x, input logic [31:0] y,
                          input int cyc, input logic [31:0] ehi, input logic [31:0] elo);
        int k = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.md_op = op; bus.src_a = x; bus.src_b = y;
        @(negedge clk);
        bus.start = 1'b0;
        while (bus.busy && k < 100) begin
            k++;
            @(negedge clk);
        end
        chk({tag, " busy cycles"}, 32'(k), 32'(cyc));
        chk({tag, " hi"}, bus.hi, ehi);
        chk({tag, " lo"}, bus.lo, elo);
    endtask

    initial begin
        reset = 1'b0;
        bus.start = 1'b0; bus.md_op = 2'b00; bus.mt_hi = 1'b0; bus.mt_lo = 1'b0;
        bus.src_a = '0; bus.src_b = '0;
        repeat (2) @(negedge clk);
        chk("reset busy", {31'b0, bus.busy}, 32'd0);
        chk("reset hi", bus.hi, 32'd0);
        chk("reset lo", bus.lo, 32'd0);
        reset = 1'b1;

        // Reset in the middle of a divide discards it and clears HI/LO
        mt(1'b1, 1'b1, 32'hAA);
        chk("mthi+mtlo hi", bus.hi, 32'hAA);
        chk("mthi+mtlo lo", bus.lo, 32'hAA);
        bus.start = 1'b1; bus.md_op = 2'b11; bus.src_a = 32'd100; bus.src_b = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid-div busy", {31'b0, bus.busy}, 32'd1);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        chk("abort busy", {31'b0, bus.busy}, 32'd0);
        chk("abort hi", bus.hi, 32'd0);
        chk("abort lo", bus.lo, 32'd0);
        repeat (12) @(negedge clk);
        chk("no late commit busy", {31'b0, bus.busy}, 32'd0);
        chk("no late commit hi", bus.hi, 32'd0);
        chk("no late commit lo", bus.lo, 32'd0);

        run_op("multu", 2'b00, 32'hFFFFFFFF, 32'd2, 5, 32'h00000001, 32'hFFFFFFFE);
        run_op("mult", 2'b01, 32'hFFFFFFFD, 32'd7, 5, 32'hFFFFFFFF, 32'hFFFFFFEB);
        run_op("mult min*-1", 2'b01, 32'h80000000, 32'hFFFFFFFF, 5, 32'h00000000, 32'h80000000);
        run_op("div", 2'b11, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divu", 2'b10, 32'hFFFFFFF9, 32'd2, 10, 32'h00000001, 32'h7FFFFFFC);
        run_op("div 7/-2", 2'b11, 32'd7, 32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD);
        run_op("div overflow", 2'b11, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000);

        mt(1'b1, 1'b0, 32'h11);
        mt(1'b0, 1'b1, 32'h22);
        run_op("div by zero", 2'b11, 32'd9, 32'd0, 10, 32'h11, 32'h22);

        // mtlo and start during RUN, then start on the commit edge: all ignored
        @(negedge clk);
        bus.start = 1'b1; bus.md_op = 2'b00; bus.src_a = 32'd3; bus.src_b = 32'd4;
        @(negedge clk);
        bus.start = 1'b0;
        c = 0;
        while (bus.busy && c < 100) begin
            c++;
            bus.start = (c == 1 || c == 5);
            bus.mt_lo = (c == 1);
            bus.md_op = 2'b10;
            bus.src_a = 32'd5; bus.src_b = 32'd1;
            @(negedge clk);
        end
        bus.start = 1'b0; bus.mt_lo = 1'b0;
        chk("run ignore busy cycles", 32'(c), 32'd5);
        chk("run ignore hi", bus.hi, 32'd0);
        chk("run ignore lo", bus.lo, 32'd12);
        @(negedge clk);
        chk("commit-edge start ignored", {31'b0, bus.busy}, 32'd0);

        mt(1'b0, 1'b1, 32'h5);
        chk("mtlo idle", bus.lo, 32'h5);

        // start wins over mthi in the same cycle
        @(negedge clk);
        bus.start = 1'b1; bus.mt_hi = 1'b1; bus.md_op = 2'b00; bus.src_a = 32'h12345; bus.src_b = 32'd1;
        @(negedge clk);
        bus.start = 1'b0; bus.mt_hi = 1'b0;
        chk("start+mthi busy", {31'b0, bus.busy}, 32'd1);
        chk("start+mthi hi held", bus.hi, 32'd0);
        c = 0;
        while (bus.busy && c < 100) begin
            c++;
            @(negedge clk);
        end
        chk("start+mthi cycles", 32'(c), 32'd5);
        chk("start+mthi hi", bus.hi, 32'd0);
        chk("start+mthi lo", bus.lo, 32'h12345);

        $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
        $finish;
    end
endmodule
